// File: rtl/uart_tx_arb_pkg.sv
// Shared types and helpers for the uart_tx round-robin arbiter.
package uart_tx_arb_pkg;

    localparam int ARB_WDT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TAG  = 2'd1,
        PASS = 2'd2
    } arb_state_t;

    // ASCII hex digit ('0'..'9', 'A'..'F') for a requester index.
    function automatic logic [7:0] id2ascii(input logic [3:0] id);
        return (id < 4'd10) ? (8'h30 + {4'h0, id}) : (8'h37 + {4'h0, id});
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational round-robin picker: first set request strictly after last_grant_i, with wrap.
module rr_prio_pick
    import uart_tx_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_grant_i,
    output logic            any_o,
    output logic [IW-1:0]   winner_o
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        any_o    = 1'b0;
        winner_o = '0;
        sum      = '0;
        idx      = '0;
        // Walk from the lowest priority offset down so the nearest requester is written last.
        for (int k = NREQ; k >= 1; k--) begin
            sum = {1'b0, last_grant_i} + (IW + 1)'(k);
            if (sum >= (IW + 1)'(NREQ)) begin
                sum = sum - (IW + 1)'(NREQ);
            end
            idx = sum[IW-1:0];
            if (req_i[idx]) begin
                any_o    = 1'b1;
                winner_o = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one uart_tx among NREQ requesters.
// Define UART_TX_ARB_TAG_EN to prefix every packet with an ASCII source-id tag beat.
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DWIDTH  = 1,
    parameter int TIMEOUT = 65535
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NREQ*DWIDTH*8-1:0]   req_data,
    input  logic [NREQ-1:0]            req_last,
    input  logic [NREQ-1:0]            req_en,
    output logic [NREQ-1:0]            req_rdy,
    output logic [DWIDTH*8-1:0]        tx_data,
    output logic                       tx_last,
    output logic                       tx_en,
    input  logic                       tx_rdy,
    output logic [$clog2(NREQ)-1:0]    grant_id,
    output logic                       busy,
    output logic                       timeout_pulse
);

    localparam int IW = $clog2(NREQ);
    localparam int BW = DWIDTH * 8;
    localparam logic [ARB_WDT_W-1:0] WDT_LIMIT = ARB_WDT_W'(TIMEOUT);

    arb_state_t           state_q;
    logic [IW-1:0]        grant_q;
    logic [IW-1:0]        last_grant_q;
    logic [ARB_WDT_W-1:0] wdt_q;
    logic [ARB_WDT_W-1:0] wdt_d;
    logic                 timeout_q;

    logic                 pick_any;
    logic [IW-1:0]        pick_winner;
    logic [BW-1:0]        sel_data;
    logic                 beat_xfer;
    logic                 wdt_hit;

    rr_prio_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req_i        (req_en),
        .last_grant_i (last_grant_q),
        .any_o        (pick_any),
        .winner_o     (pick_winner)
    );

    assign sel_data      = req_data[grant_q*BW +: BW];
    assign beat_xfer     = tx_en & tx_rdy;
    assign wdt_d         = wdt_q + 1'b1;
    assign wdt_hit       = (TIMEOUT != 0) && (wdt_d == WDT_LIMIT);
    assign grant_id      = grant_q;
    assign busy          = (state_q != IDLE);
    assign timeout_pulse = timeout_q;

    // Downstream beat and requester acknowledge are a pure function of state and grant.
    always_comb begin
        tx_data = '0;
        tx_last = 1'b0;
        tx_en   = 1'b0;
        req_rdy = '0;
        case (state_q)
            PASS: begin
                tx_data          = sel_data;
                tx_last          = req_last[grant_q];
                tx_en            = req_en[grant_q];
                req_rdy[grant_q] = tx_rdy;
            end
`ifdef UART_TX_ARB_TAG_EN
            TAG: begin
                tx_en = 1'b1;
                for (int l = 0; l < DWIDTH; l++) begin
                    tx_data[l*8 +: 8] = (l == 0) ? id2ascii(4'(grant_q)) : 8'h20;
                end
            end
`endif
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IW'(NREQ - 1);
            wdt_q        <= '0;
            timeout_q    <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        grant_q <= pick_winner;
                        wdt_q   <= '0;
`ifdef UART_TX_ARB_TAG_EN
                        state_q <= TAG;
`else
                        state_q <= PASS;
`endif
                    end
                end
`ifdef UART_TX_ARB_TAG_EN
                TAG: begin
                    if (tx_rdy) begin
                        state_q <= PASS;
                        wdt_q   <= '0;
                    end
                end
`endif
                PASS: begin
                    if (beat_xfer) begin
                        wdt_q <= '0;
                        if (tx_last) begin
                            last_grant_q <= grant_q;
                            state_q      <= IDLE;
                        end
                    end else if (wdt_hit) begin
                        // Stalled requester: give the line back without a closing beat.
                        timeout_q    <= 1'b1;
                        last_grant_q <= grant_q;
                        wdt_q        <= '0;
                        state_q      <= IDLE;
                    end else begin
                        wdt_q <= wdt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed packets, fairness, backpressure, watchdog, reset.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } beat_t;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic clk;
    logic rstn;

    logic [NREQ*8-1:0] req_data;
    logic [NREQ-1:0]   req_last, req_en, req_rdy;
    logic [7:0]        tx_data;
    logic              tx_last, tx_en, tx_rdy;
    logic [1:0]        grant_id;
    logic              busy, timeout_pulse;

    logic [NREQ*8-1:0] w_data;
    logic [NREQ-1:0]   w_last, w_en, w_req_rdy;
    logic [7:0]        w_tx_data;
    logic              w_tx_last, w_tx_en, w_tx_rdy;
    logic [1:0]        w_grant;
    logic              w_busy, w_tmo;

    int     vectors = 0;
    int     miscompares = 0;
    int     cyc = 0;
    int     last_cyc = 0;
    int     stall_cnt = 0;
    logic   chk_gap = 1'b0;
    logic   await_first = 1'b0;
    logic [NREQ-1:0] hs_prev;

    beat_t rq[NREQ][$];
    exp_t  exp_q[$];

    uart_tx_arbiter #(.NREQ(NREQ), .DWIDTH(1), .TIMEOUT(64)) dut (
        .clk(clk), .rstn(rstn),
        .req_data(req_data), .req_last(req_last), .req_en(req_en), .req_rdy(req_rdy),
        .tx_data(tx_data), .tx_last(tx_last), .tx_en(tx_en), .tx_rdy(tx_rdy),
        .grant_id(grant_id), .busy(busy), .timeout_pulse(timeout_pulse)
    );

    uart_tx_arbiter #(.NREQ(NREQ), .DWIDTH(1), .TIMEOUT(8)) dut_wd (
        .clk(clk), .rstn(rstn),
        .req_data(w_data), .req_last(w_last), .req_en(w_en), .req_rdy(w_req_rdy),
        .tx_data(w_tx_data), .tx_last(w_tx_last), .tx_en(w_tx_en), .tx_rdy(w_tx_rdy),
        .grant_id(w_grant), .busy(w_busy), .timeout_pulse(w_tmo)
    );

`ifdef UART_TX_ARB_TAG_EN
    logic [127:0] t_data;
    logic [15:0]  t_last, t_en, t_req_rdy;
    logic [7:0]   t_tx_data;
    logic         t_tx_last, t_tx_en, t_tx_rdy;
    logic [3:0]   t_grant;
    logic         t_busy, t_tmo;

    uart_tx_arbiter #(.NREQ(16), .DWIDTH(1), .TIMEOUT(64)) dut_tag (
        .clk(clk), .rstn(rstn),
        .req_data(t_data), .req_last(t_last), .req_en(t_en), .req_rdy(t_req_rdy),
        .tx_data(t_tx_data), .tx_last(t_tx_last), .tx_en(t_tx_en), .tx_rdy(t_tx_rdy),
        .grant_id(t_grant), .busy(t_busy), .timeout_pulse(t_tmo)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Queues one packet on a requester and its expected downstream beats.
    task automatic push_pkt(input int id, input logic [7:0] d0, input int n);
`ifdef UART_TX_ARB_TAG_EN
        exp_q.push_back('{id: 2'(id), data: 8'h30 + 8'(id), last: 1'b0});
`endif
        for (int b = 0; b < n; b++) begin
            rq[id].push_back('{last: (b == n - 1), data: d0 + 8'(b)});
            exp_q.push_back('{id: 2'(id), data: d0 + 8'(b), last: (b == n - 1)});
        end
    endtask

    function automatic logic rq_pending();
        logic p = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (rq[i].size() != 0) p = 1'b1;
        end
        return p;
    endfunction

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy || rq_pending()) && n < 500) begin
            @(negedge clk);
            #3;
            n++;
        end
        check({name, "_left"}, 32'(exp_q.size()), 0);
        check({name, "_idle"}, 32'(busy), 0);
    endtask

    task automatic reset_checks(input string name);
        check({name, "_busy"}, 32'(busy), 0);
        check({name, "_tx_en"}, 32'(tx_en), 0);
        check({name, "_tx_last"}, 32'(tx_last), 0);
        check({name, "_tx_data"}, 32'(tx_data), 0);
        check({name, "_req_rdy"}, 32'(req_rdy), 0);
        check({name, "_grant_id"}, 32'(grant_id), 0);
        check({name, "_timeout"}, 32'(timeout_pulse), 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #3 rstn = 1'b0;
        @(negedge clk);
        #3 rstn = 1'b1;
    endtask

    // Requester models: present queue heads, retire a beat after it was accepted.
    initial begin
        req_en   = '0;
        req_data = '0;
        req_last = '0;
        tx_rdy   = 1'b1;
        hs_prev  = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (rstn && hs_prev[i] && rq[i].size() != 0) void'(rq[i].pop_front());
            end
            for (int i = 0; i < NREQ; i++) begin
                if (rq[i].size() != 0) begin
                    req_en[i]         = 1'b1;
                    req_data[i*8 +: 8] = rq[i][0].data;
                    req_last[i]       = rq[i][0].last;
                end else begin
                    req_en[i]         = 1'b0;
                    req_data[i*8 +: 8] = 8'h00;
                    req_last[i]       = 1'b0;
                end
            end
            tx_rdy = (stall_cnt == 0);
            #1;
            if (!tx_rdy) begin
                check("bp_req_rdy", 32'(req_rdy), 0);
                check("bp_timeout", 32'(timeout_pulse), 0);
                stall_cnt--;
            end
            hs_prev = req_en & req_rdy;
        end
    end

    // Monitor: compares every accepted downstream beat against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rstn) begin
                await_first = 1'b0;
            end else begin
                check("no_timeout_main", 32'(timeout_pulse), 0);
                if (!busy) check("idle_quiet", {27'd0, req_rdy, tx_en}, 0);
                if (tx_en && chk_gap && await_first) begin
                    check("bubble_gap", 32'(cyc - last_cyc), 2);
                    await_first = 1'b0;
                end
                if (tx_en && tx_rdy) begin
                    check("beat_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("beat_data", 32'(tx_data), 32'(e.data));
                        check("beat_last", 32'(tx_last), 32'(e.last));
                        check("beat_grant", 32'(grant_id), 32'(e.id));
                    end
                    if (tx_last) begin
                        last_cyc    = cyc;
                        await_first = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int idle;
        int n;
        logic saw;
        rstn     = 1'b0;
        w_en     = '0;
        w_data   = '0;
        w_last   = '0;
        w_tx_rdy = 1'b1;
`ifdef UART_TX_ARB_TAG_EN
        t_en = '0; t_data = '0; t_last = '0; t_tx_rdy = 1'b1;
`endif
        repeat (3) @(negedge clk);
        #1 reset_checks("reset");
        @(negedge clk);
        #3 rstn = 1'b1;

        // Basic pass-through from requester 2.
        push_pkt(2, 8'h41, 3);
        wait_drain("basic");
        check("basic_grant_id", 32'(grant_id), 2);

        // Fairness from reset: all requesters hold two 2-beat packets each.
        pulse_reset();
        chk_gap = 1'b1;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < NREQ; i++) push_pkt(i, 8'(8'h10 * i + 8'h80 * p), 2);
        end
        wait_drain("fair");
        chk_gap = 1'b0;

        // Backpressure: 10 stalled cycles after the first beat of a 4-beat packet.
        push_pkt(3, 8'hC0, 4);
        n = 0;
        while (exp_q.size() > 3 && n < 50) begin
            @(negedge clk);
            #3;
            n++;
        end
        check("bp_first_beat", 32'(exp_q.size()), 3);
        stall_cnt = 10;
        wait_drain("bp");
        check("bp_stall_done", 32'(stall_cnt), 0);

        // Async reset mid-packet; requester 0 must win first afterwards.
        push_pkt(0, 8'hD0, 1);
        wait_drain("pre_rst");
        push_pkt(2, 8'hE0, 4);
        n = 0;
        while (exp_q.size() > 3 && n < 50) begin
            @(negedge clk);
            #3;
            n++;
        end
        @(negedge clk);
        #3 rstn = 1'b0;
        #1 reset_checks("midrst");
        for (int i = 0; i < NREQ; i++) rq[i].delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        #3 rstn = 1'b1;
        push_pkt(0, 8'hA0, 1);
        push_pkt(1, 8'hA1, 1);
        wait_drain("post_rst");

        // Watchdog (TIMEOUT=8): requester 1 stalls after one beat, requester 2 waits.
        @(negedge clk);
        w_en[1] = 1'b1; w_data[15:8]  = 8'h11; w_last[1] = 1'b0;
        w_en[2] = 1'b1; w_data[23:16] = 8'h22; w_last[2] = 1'b1;
`ifdef UART_TX_ARB_TAG_EN
        @(negedge clk);
`endif
        @(negedge clk);
        #1;
        check("wd_grant1", 32'(w_grant), 1);
        check("wd_data1", 32'(w_tx_data), 32'h11);
        check("wd_rdy1", 32'(w_req_rdy), 32'b0010);
        @(negedge clk);
        w_en[1] = 1'b0;
        idle = 0;
        saw  = 1'b0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (w_tmo) begin
                saw = 1'b1;
                break;
            end
            if (w_busy) idle++;
            @(negedge clk);
        end
        check("wd_pulse_seen", 32'(saw), 1);
        check("wd_idle_cycles", 32'(idle), 8);
        check("wd_release_idle", 32'(w_busy), 0);
`ifdef UART_TX_ARB_TAG_EN
        @(negedge clk);
`endif
        @(negedge clk);
        #1;
        check("wd_pulse_width", 32'(w_tmo), 0);
        check("wd_grant2", 32'(w_grant), 2);
        check("wd_data2", 32'(w_tx_data), 32'h22);
        check("wd_last2", 32'(w_tx_last), 1);
        @(negedge clk);
        w_en = '0;

`ifdef UART_TX_ARB_TAG_EN
        // Tag beat: requester 11 sends one beat 8'h55, preceded by 'B'.
        @(negedge clk);
        t_en[11] = 1'b1; t_data[95:88] = 8'h55; t_last[11] = 1'b1;
        @(negedge clk);
        #1;
        check("tag_beat_data", 32'(t_tx_data), 32'h42);
        check("tag_beat_last", 32'(t_tx_last), 0);
        check("tag_beat_rdy", 32'(t_req_rdy), 0);
        check("tag_grant", 32'(t_grant), 11);
        @(negedge clk);
        #1;
        check("tag_pkt_data", 32'(t_tx_data), 32'h55);
        check("tag_pkt_last", 32'(t_tx_last), 1);
        check("tag_pkt_rdy", 32'(t_req_rdy), 32'h0800);
        @(negedge clk);
        t_en = '0;
        #1 check("tag_done", 32'(t_busy), 0);
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
